mul4x2_by_2x2_matrix: RTL and testbench
=======================================

// Module: mul4x2_by_2x2_matrix
// PURPOSE
//  Multiplies a 4x2 matrix A by a 2x2 matrix B.
//  All elements are unsigned and the result S = A*B is a 4x2 matrix.
//  This is a pipelined datapath leaf for the small-ML compute path.
//  Operands are sampled on a valid strobe; the result is registered with fixed 1-cycle latency.
//  There is no backpressure.
// PARAMETERS
//  DW  4       element width of A and B (unsigned)
//  OW  2*DW+1  result element width; 9 at default; max 2*(2^DW-1)^2 = 450 fits
// PORTS
//  clk       in   1   rising-edge clock
//  rst       in   1   synchronous active-high reset
//  in_valid  in   1   operands valid this cycle
//  a0,a1     in   DW  A row 0 (A[0][0], A[0][1])
//  a2,a3     in   DW  A row 1
//  a4,a5     in   DW  A row 2
//  a6,a7     in   DW  A row 3
//  b0,b1     in   DW  B row 0 (B[0][0], B[0][1])
//  b2,b3     in   DW  B row 1
//  s0,s1     out  OW  S row 0 (S[0][0], S[0][1])
//  s2,s3     out  OW  S row 1
//  s4,s5     out  OW  S row 2
//  s6,s7     out  OW  S row 3
//  out_valid out  1   s0..s7 updated with a new result this cycle
// BEHAVIOUR
//  - Indexing is row-major for all three matrices:
//    A[r][c] = a(2r+c), B[r][c] = b(2r+c), S[r][c] = s(2r+c).
//  - Result: S[r][c] = A[r][0]*B[0][c] + A[r][1]*B[1][c], for r=0..3, c=0..1.
//  - Arithmetic is fully unsigned.
//    - Each product is 2*DW bits wide.
//    - The sum is OW bits wide, so it cannot overflow and never wraps or saturates.
//  - Sampling: on a rising clk edge with rst=0 and in_valid=1:
//    - all 8 results are computed from the current inputs and registered;
//    - out_valid goes to 1 on that same edge (latency 1 cycle).
//  - On a rising clk edge with rst=0 and in_valid=0:
//    - s0..s7 hold their last value;
//    - out_valid goes to 0.
//  - Back-to-back in_valid is allowed.
//    - One result is produced per cycle, with full throughput.
//    - There is no internal state besides the output registers.
//  - Reset: on a rising edge with rst=1, s0..s7 go to 0 and out_valid goes to 0.
//    - rst takes priority over in_valid.
//    - Operands presented in the same cycle as rst are discarded.
//  - Outputs are driven from registers only.
//    - There is no combinational path from inputs to outputs.
//  - Inputs are allowed to change freely between edges and are only looked at on the edge.
// TESTING
//  1. Reset:
//     - Stimulus: rst=1 for 2 cycles with in_valid=1 and nonzero operands.
//     - Required: s0..s7 = 0, out_valid = 0.
//  2. Basic case:
//     - Stimulus: A=[1 2;2 2;2 1;2 3], B=[6 5;1 3], in_valid=1.
//     - Required, 1 cycle later: S=[8 11;14 16;13 13;15 19], out_valid=1.
//  3. Changed A rows 0 and 3:
//     - Stimulus: A=[7 2;2 2;2 1;2 6], same B, issued back-to-back after case 2.
//     - Required, next cycle: S=[44 41;14 16;13 13;18 28].
//  4. Max range:
//     - Stimulus: all a*=15, all b*=15.
//     - Required: every s = 450 (9'h1C2), with no overflow.
//  5. Hold:
//     - Stimulus: drop in_valid and change the operands.
//     - Required: s0..s7 unchanged, out_valid = 0.
//  6. Mid-stream reset:
//     - Stimulus: assert rst in the same cycle as in_valid=1.
//     - Required: outputs go to 0; the operands are not reflected afterwards.

Source files
------------

// File: rtl/mul4x2_by_2x2_matrix_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul4x2_by_2x2_matrix_if
//  Description : Operand and result bundle for the 4x2 by 2x2 matrix multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul4x2_by_2x2_matrix_if #(
    parameter int DW = 4,
    parameter int OW = 2*DW+1
);
    logic          in_valid;
    logic [DW-1:0] a0, a1, a2, a3, a4, a5, a6, a7;
    logic [DW-1:0] b0, b1, b2, b3;
    logic [OW-1:0] s0, s1, s2, s3, s4, s5, s6, s7;
    logic          out_valid;

    modport master (
        output in_valid, a0, a1, a2, a3, a4, a5, a6, a7, b0, b1, b2, b3,
        input  s0, s1, s2, s3, s4, s5, s6, s7, out_valid
    );

    modport slave (
        input  in_valid, a0, a1, a2, a3, a4, a5, a6, a7, b0, b1, b2, b3,
        output s0, s1, s2, s3, s4, s5, s6, s7, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mul4x2_by_2x2_matrix.sv
`default_nettype none
// ============================================================================
//  Module      : mul4x2_by_2x2_matrix
//  Description : Unsigned S = A(4x2) * B(2x2), operands sampled on in_valid,
//                results registered with a fixed one-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul4x2_by_2x2_matrix #(
    parameter int DW = 4,
    parameter int OW = 2*DW+1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    mul4x2_by_2x2_matrix_if.slave  mm
);
    logic [DW-1:0] w_a   [8];
    logic [DW-1:0] w_b   [4];
    logic [OW-1:0] w_sum [8];
    logic [OW-1:0] r_s   [8];
    logic          r_valid;

    assign w_a[0] = mm.a0;
    assign w_a[1] = mm.a1;
    assign w_a[2] = mm.a2;
    assign w_a[3] = mm.a3;
    assign w_a[4] = mm.a4;
    assign w_a[5] = mm.a5;
    assign w_a[6] = mm.a6;
    assign w_a[7] = mm.a7;
    assign w_b[0] = mm.b0;
    assign w_b[1] = mm.b1;
    assign w_b[2] = mm.b2;
    assign w_b[3] = mm.b3;

    // S[r][c] = A[r][0]*B[0][c] + A[r][1]*B[1][c]; OW bits hold the worst case
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 2; c++) begin : g_col
            logic [2*DW-1:0] w_p0;
            logic [2*DW-1:0] w_p1;
            assign w_p0 = w_a[2*r]   * w_b[c];
            assign w_p1 = w_a[2*r+1] * w_b[2+c];
            assign w_sum[2*r+c] = OW'(w_p0) + OW'(w_p1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_s[i] <= '0;
            end
            r_valid <= 1'b0;
        end else begin
            r_valid <= mm.in_valid;
            if (mm.in_valid) begin
                for (int i = 0; i < 8; i++) begin
                    r_s[i] <= w_sum[i];
                end
            end
        end
    end

    assign mm.s0       = r_s[0];
    assign mm.s1       = r_s[1];
    assign mm.s2       = r_s[2];
    assign mm.s3       = r_s[3];
    assign mm.s4       = r_s[4];
    assign mm.s5       = r_s[5];
    assign mm.s6       = r_s[6];
    assign mm.s7       = r_s[7];
    assign mm.out_valid = r_valid;
endmodule
`default_nettype wire

// File: tb/tb_mul4x2_by_2x2_matrix.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul4x2_by_2x2_matrix
//  Description : Directed and random checks of the 4x2 by 2x2 matrix multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul4x2_by_2x2_matrix;
    localparam int DW = 4;
    localparam int OW = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mul4x2_by_2x2_matrix_if #(.DW(DW), .OW(OW)) mm ();

    mul4x2_by_2x2_matrix #(.DW(DW), .OW(OW)) dut (
        .clk (clk),
        .rst (rst),
        .mm  (mm)
    );

    always #5 clk = ~clk;

    int unsigned a_m [8];
    int unsigned b_m [4];
    int unsigned exp_s [8];
    bit          exp_v;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic get_s(output logic [31:0] s [8]);
        s[0] = {23'b0, mm.s0};
        s[1] = {23'b0, mm.s1};
        s[2] = {23'b0, mm.s2};
        s[3] = {23'b0, mm.s3};
        s[4] = {23'b0, mm.s4};
        s[5] = {23'b0, mm.s5};
        s[6] = {23'b0, mm.s6};
        s[7] = {23'b0, mm.s7};
    endtask

    task automatic check_model(input string tag);
        logic [31:0] s [8];
        get_s(s);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s.s%0d", tag, i), s[i], exp_s[i]);
        end
        check($sformatf("%s.out_valid", tag), {31'b0, mm.out_valid}, {31'b0, exp_v});
    endtask

    task automatic check_const(input string tag, input int unsigned ref_s [8]);
        logic [31:0] s [8];
        get_s(s);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s.const_s%0d", tag, i), s[i], ref_s[i]);
        end
    endtask

    // Apply operands for one edge, advance the reference matrix product, then check
    task automatic step(input bit r, input bit v, input string tag);
        rst         = r;
        mm.in_valid = v;
        mm.a0 = 4'(a_m[0]); mm.a1 = 4'(a_m[1]); mm.a2 = 4'(a_m[2]); mm.a3 = 4'(a_m[3]);
        mm.a4 = 4'(a_m[4]); mm.a5 = 4'(a_m[5]); mm.a6 = 4'(a_m[6]); mm.a7 = 4'(a_m[7]);
        mm.b0 = 4'(b_m[0]); mm.b1 = 4'(b_m[1]); mm.b2 = 4'(b_m[2]); mm.b3 = 4'(b_m[3]);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 8; i++) exp_s[i] = 0;
            exp_v = 1'b0;
        end else begin
            exp_v = v;
            if (v) begin
                for (int row = 0; row < 4; row++)
                    for (int col = 0; col < 2; col++)
                        exp_s[2*row+col] = a_m[2*row] * b_m[col] + a_m[2*row+1] * b_m[2+col];
            end
        end
        #1;
        check_model(tag);
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < 8; i++) a_m[i] = $urandom_range(0, 15);
        for (int i = 0; i < 4; i++) b_m[i] = $urandom_range(0, 15);
    endtask

    initial begin
        int unsigned c2 [8];
        int unsigned c3 [8];
        int unsigned c4 [8];
        c2 = '{8, 11, 14, 16, 13, 13, 15, 19};
        c3 = '{44, 41, 14, 16, 13, 13, 18, 28};
        c4 = '{450, 450, 450, 450, 450, 450, 450, 450};
        for (int i = 0; i < 8; i++) exp_s[i] = 0;
        exp_v = 1'b0;

        // Reset held with live, nonzero operands
        a_m = '{9, 8, 7, 6, 5, 4, 3, 2};
        b_m = '{1, 2, 3, 4};
        step(1'b1, 1'b1, "reset0");
        step(1'b1, 1'b1, "reset1");

        a_m = '{1, 2, 2, 2, 2, 1, 2, 3};
        b_m = '{6, 5, 1, 3};
        step(1'b0, 1'b1, "basic");
        check_const("basic", c2);

        a_m = '{7, 2, 2, 2, 2, 1, 2, 6};
        step(1'b0, 1'b1, "b2b");
        check_const("b2b", c3);

        for (int i = 0; i < 8; i++) a_m[i] = 15;
        for (int i = 0; i < 4; i++) b_m[i] = 15;
        step(1'b0, 1'b1, "max");
        check_const("max", c4);

        randomize_ops();
        step(1'b0, 1'b0, "hold0");
        check_const("hold0", c4);
        randomize_ops();
        step(1'b0, 1'b0, "hold1");
        check_const("hold1", c4);

        for (int n = 0; n < 200; n++) begin
            randomize_ops();
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), $sformatf("rand%0d", n));
        end

        a_m = '{1, 2, 2, 2, 2, 1, 2, 3};
        b_m = '{6, 5, 1, 3};
        step(1'b0, 1'b1, "pre_rst");
        check_const("pre_rst", c2);
        randomize_ops();
        step(1'b1, 1'b1, "mid_rst");
        step(1'b0, 1'b0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
